// File: rtl/v_rams_stream_reader.sv
// Block read controller for a 1-cycle-latency BRAM. Issues consecutive
// (wrapping) reads and presents them as a valid/ready stream through a
// 2-entry skid FIFO, so backpressure never loses or duplicates a word.
module v_rams_stream_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, issue_addr;
  logic [CW-1:0]         len_q, issued_q;
  logic                  inflight_q, inflight_last_q, done_q;
  beat_t                 fifo_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q;
  logic [2:0]            need;
  logic                  pop, accept, issue_last, finish;

  assign m_valid    = (occ_q != 2'd0);
  assign pop        = m_valid & m_ready;
  assign m_data     = fifo_q[rd_ptr_q].data;
  assign m_last     = m_valid & fifo_q[rd_ptr_q].last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign accept     = (state_q == IDLE) & start & (length != '0) & (length <= DEPTH);
  assign issue_last = (issued_q == len_q - CW'(1));
  assign issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  // Slots committed after this edge; a pop this cycle frees one in time for
  // the read issued now, which keeps full throughput with m_ready high.
  assign need       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign ram_en     = (state_q == READ) & (issued_q != len_q) & (need < 3'd2);
  assign ram_addr   = ram_en ? issue_addr : addr_q;
  assign finish     = (state_q == DRAIN) & pop & m_last;

  // Next-state logic: leave READ on the last issue, leave DRAIN on the last pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (ram_en && issue_last) state_d = DRAIN;
      DRAIN:   if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: command latch, issue counter, in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      done_q          <= finish;
      inflight_q      <= ram_en;
      inflight_last_q <= ram_en & issue_last;
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
      end else if (ram_en) begin
        issued_q <= issued_q + CW'(1);
        addr_q   <= issue_addr;
      end
    end
  end

  // Output FIFO: capture RAM data one cycle after its read, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= '0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= '{last: inflight_last_q, data: ram_do};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_v_rams_stream_reader.sv
// Bench for v_rams_stream_reader: table of transfers plus random transfers,
// each checked beat-by-beat against a word list built from the RAM image.
module tb_v_rams_stream_reader;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_en, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  v_rams_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_do(ram_do), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM model: registered read
  always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;      // 0: ready=1, 1: pattern 1,0,0,1,0,1, 2: random
    bit            poke;      // pulse start while busy
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_final;
  } vec_t;

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [DW-1:0] first_d, final_d;

  // One complete transfer. If pre=1 the start was already driven in the
  // previous done cycle. If nxt=1 a new start is driven in this done cycle.
  task automatic run_xfer(input logic [AW-1:0] b, input int l, input int mode,
                          input bit poke, input bit pre, input bit nxt,
                          input logic [AW-1:0] nb, input int nl);
    logic [DW-1:0] expd [$];
    int cyc = 0, issued = 0, popped = 0;
    bit done_seen = 0, prev_stall = 0;
    logic [DW-1:0] held_d;
    logic held_l;
    for (int i = 0; i < l; i++) expd.push_back(mem[(int'(b) + i) % DEPTH]);
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; base_addr = b; length = (AW+1)'(l);
    end
    @(posedge clk); #1 start = 1'b0;
    while (!done_seen && cyc < 600) begin
      cyc++;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = pat[(cyc - 1) % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 2) begin start = 1'b1; base_addr = b + 6'd9; length = 7'd3; end
      if (poke && cyc == 3) start = 1'b0;
      @(negedge clk);
      if (ram_en) begin
        chk("ram_addr", 32'(ram_addr), 32'((int'(b) + issued) % DEPTH));
        if (issued == 0) chk("first_en_cycle", cyc, 1);
        issued++;
        chk("issue_le_len", 32'(issued <= l), 1);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(held_d));
        chk("stall_last", 32'(m_last), 32'(held_l));
      end
      if (m_valid && m_ready) begin
        chk("m_data", 32'(m_data), 32'(expd[popped]));
        chk("m_last", 32'(m_last), 32'(popped == l - 1));
        if (popped == 0) first_d = m_data;
        final_d = m_data;
        popped++;
      end
      chk("outstanding_le_2", 32'((issued - popped) <= 2), 1);
      if (mode == 0) begin
        chk("m_valid_timing", 32'(m_valid), 32'(cyc >= 3 && cyc <= l + 2));
        chk("busy_timing", 32'(busy), 32'(cyc <= l + 2));
      end
      if (done) begin
        done_seen = 1;
        chk("done_words", popped, l);
        chk("done_issued", issued, l);
        chk("done_busy", 32'(busy), 0);
        if (mode == 0) chk("done_cycle", cyc, l + 3);
        if (nxt) begin start = 1'b1; base_addr = nb; length = (AW+1)'(nl); end
      end
      prev_stall = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (!done_seen) begin @(posedge clk); #1; end
    end
    if (!done_seen) chk("xfer_timeout", 0, 1);
  endtask

  task automatic run_illegal(input int l);
    @(negedge clk);
    start = 1'b1; base_addr = 6'd3; length = (AW+1)'(l);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("illegal_quiet", {29'd0, busy, done, ram_en}, 0);
    end
  endtask

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 16'h100);
    vecs[0] = '{6'd5,  7'd4,  0, 1'b0, 16'h105, 16'h108};
    vecs[1] = '{6'd62, 7'd4,  0, 1'b0, 16'h13E, 16'h101};
    vecs[2] = '{6'd10, 7'd8,  1, 1'b0, 16'h10A, 16'h111};
    vecs[3] = '{6'd0,  7'd64, 0, 1'b0, 16'h100, 16'h13F};
    vecs[4] = '{6'd33, 7'd64, 2, 1'b0, 16'h121, 16'h120};
    vecs[5] = '{6'd63, 7'd1,  2, 1'b0, 16'h13F, 16'h13F};
    vecs[6] = '{6'd20, 7'd13, 2, 1'b1, 16'h114, 16'h120};

    // reset state
    #2;
    chk("rst_outs", {25'd0, busy, done, ram_en, m_valid, m_last, 2'b0}, 0);
    chk("rst_addr_data", {10'd0, ram_addr, m_data}, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].base, int'(vecs[i].len), vecs[i].mode, vecs[i].poke,
               1'b0, 1'b0, '0, 0);
      chk("vec_first", 32'(first_d), 32'(vecs[i].exp_first));
      chk("vec_final", 32'(final_d), 32'(vecs[i].exp_final));
    end

    for (int r = 0; r < 8; r++)
      run_xfer(6'($urandom_range(0, 63)), int'($urandom_range(1, 64)), 2,
               1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 0);

    run_illegal(0);
    run_illegal(65);
    run_illegal(127);

    // start in the done cycle launches the next transfer immediately
    run_xfer(6'd7, 3, 0, 1'b0, 1'b0, 1'b1, 6'd50, 5);
    run_xfer(6'd50, 5, 0, 1'b0, 1'b1, 1'b0, '0, 0);

    // reset mid-transfer with words buffered and a read in flight
    @(negedge clk);
    start = 1'b1; base_addr = 6'd0; length = 7'd8;
    @(posedge clk); #1 start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 32'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {25'd0, busy, done, ram_en, m_valid, m_last, 2'b0}, 0);
    chk("abort_addr_data", {10'd0, ram_addr, m_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_idle", {29'd0, busy, done, m_valid}, 0);
    end
    run_xfer(6'd0, 1, 0, 1'b0, 1'b0, 1'b0, '0, 0);
    chk("post_reset_word", 32'(final_d), 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
